// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   Runs one load or store against a word-wide data memory bus that uses a
//   req/gnt/rvalid handshake. Stores get byte enables and lane-replicated data.
//   Loads get lane selection plus sign or zero extension. The core stalls while
//   busy is high and takes rdata, err and misalign when done pulses.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   req                start an op (only looked at while idle)
//   memwr              1 = store, 0 = load
//   memop[2:0]         000 b, 001 h, 010 w, 100 bu, 101 hu
//   addr[31:0]         byte address
//   wdata[31:0]        store data
//   busy               high whenever an op is in flight
//   done               one-cycle completion pulse
//   rdata[31:0]        load result, held until the next done
//   misalign, err      completion status, only valid with done
//   mem_req/we/addr/be/wdata   bus request side, stable until mem_gnt
//   mem_gnt            bus accepts the request this cycle
//   mem_rvalid/rdata   read data return
//
// Parameter
//   TIMEOUT            max cycles spent in REQ+RWAIT before aborting (>=2)
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        memwr,
  input  logic [2:0]  memop,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_RWAIT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [2:0]    op_q, op_d;
  logic [1:0]    off_q, off_d;
  logic          eflag_q, eflag_d;
  logic          mflag_q, mflag_d;
  logic [31:0]   res_q, res_d;

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          misalign_q, misalign_d;
  logic          err_q, err_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;

  // Picks the addressed byte/half out of the returned word and extends it.
  function automatic logic [31:0] ld_extract(input logic [2:0] op,
                                             input logic [1:0] off,
                                             input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (op)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  logic illegal, misal;
  logic [3:0]  st_be;
  logic [31:0] st_data;

  always_comb begin
    // Stores with the unsigned bit set have no meaning, same as 011/11x.
    illegal = (memop == 3'b011) || (memop == 3'b110) || (memop == 3'b111) ||
              (memwr && memop[2]);
    misal   = ((memop[1:0] == 2'b01) && addr[0]) ||
              ((memop[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    case (memop[1:0])
      2'b00: begin
        st_be   = 4'b0001 << addr[1:0];
        st_data = {4{wdata[7:0]}};
      end
      2'b01: begin
        st_be   = addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wdata[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = wdata;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    op_d        = op_q;
    off_d       = off_q;
    eflag_d     = eflag_q;
    mflag_d     = mflag_q;
    res_d       = res_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          wr_d    = memwr;
          op_d    = memop;
          off_d   = addr[1:0];
          cnt_d   = '0;
          res_d   = '0;
          eflag_d = 1'b0;
          mflag_d = 1'b0;
          if (illegal) begin
            eflag_d = 1'b1;
            state_d = S_DONE;
          end else if (misal) begin
            mflag_d = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d     = S_REQ;
            mem_we_d    = memwr;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_be_d    = memwr ? st_be : 4'b1111;
            mem_wdata_d = memwr ? st_data : 32'd0;
          end
        end
      end
      S_REQ: begin
        // A grant in the last allowed cycle still wins over the timeout.
        if (mem_gnt) begin
          state_d = wr_q ? S_DONE : S_RWAIT;
          cnt_d   = cnt_q + 1'b1;
        end else if (cnt_q >= CNT_LAST) begin
          eflag_d = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RWAIT: begin
        if (mem_rvalid) begin
          res_d   = ld_extract(op_q, off_q, mem_rdata);
          state_d = S_DONE;
        end else if (cnt_q >= CNT_LAST) begin
          eflag_d = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are flopped; done lands one cycle after DONE, which is what
    // gives the 2/3/4-cycle error/store/load latencies.
    busy_d     = (state_d != S_IDLE);
    mem_req_d  = (state_d == S_REQ);
    done_d     = (state_q == S_DONE);
    err_d      = done_d && eflag_q;
    misalign_d = done_d && mflag_q;
    rdata_d    = done_d ? res_q : rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      op_q        <= 3'd0;
      off_q       <= 2'd0;
      eflag_q     <= 1'b0;
      mflag_q     <= 1'b0;
      res_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rdata_q     <= '0;
      misalign_q  <= 1'b0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      op_q        <= op_d;
      off_q       <= off_d;
      eflag_q     <= eflag_d;
      mflag_q     <= mflag_d;
      res_q       <= res_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      misalign_q  <= misalign_d;
      err_q       <= err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign misalign  = misalign_q;
  assign err       = err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//   Directed plus randomized load/store traffic against a bus responder with
//   programmable grant and read-data delays. Expected results come from a
//   reference model written straight from the load/store rules.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;
  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, memwr;
  logic [2:0]  memop;
  logic [31:0] addr, wdata;
  logic        busy, done, misalign, err;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int errs = 0;
  int checks = 0;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .memwr(memwr), .memop(memop),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .misalign(misalign), .err(err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---- reference model ----
  function automatic logic [31:0] ld_ref(input logic [2:0] op, input logic [1:0] a,
                                         input logic [31:0] w);
    int unsigned v;
    v = w;
    case (op)
      3'b000, 3'b100: begin
        v = (v >> (8 * a)) & 32'hFF;
        if (op == 3'b000 && v >= 128) v = v + 32'hFFFF_FF00;
      end
      3'b001, 3'b101: begin
        v = (v >> (16 * (a / 2))) & 32'hFFFF;
        if (op == 3'b001 && v >= 32768) v = v + 32'hFFFF_0000;
      end
      default: ;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] be_ref(input logic [2:0] op, input logic [1:0] a);
    if (op == 3'b000) return 4'(1 << a);
    if (op == 3'b001) return (a >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] wd_ref(input logic [2:0] op, input logic [31:0] d);
    if (op == 3'b000) return (d & 32'hFF) * 32'h0101_0101;
    if (op == 3'b001) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  // One operation with a scripted bus. gdly: cycles of mem_req before gnt
  // (>=TO means never). rdly: cycles from gnt to rvalid.
  task automatic do_op(input string nm, input logic wr, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] word, input int gdly, input int rdly,
                       input bit junk);
    bit ill, mis, tmo, exp_err, req_seen, got_done;
    int exp_lat, n, granted;
    ill = (op == 3'd3) || (op == 3'd6) || (op == 3'd7) || (wr && op[2]);
    mis = !ill && ((op[1:0] == 2'd1 && a[0]) || (op[1:0] == 2'd2 && a[1:0] != 2'd0));
    tmo = !ill && !mis && (gdly >= TO);
    exp_err = ill || tmo;
    if (ill || mis)   exp_lat = 2;
    else if (tmo)     exp_lat = TO + 2;
    else if (wr)      exp_lat = gdly + 3;
    else              exp_lat = gdly + rdly + 3;

    req = 1'b1; memwr = wr; memop = op; addr = a; wdata = wd;
    step();
    req = 1'b0;
    n = 1; granted = -1; req_seen = 0; got_done = 0;
    while (n <= 200) begin
      if (done) begin
        got_done = 1;
        break;
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (granted > 0 && n == granted + 1) chk({nm, ":req_drop"}, 32'(mem_req), 32'd0);
      if (mem_req) begin
        req_seen = 1;
        chk({nm, ":addr"}, mem_addr, {a[31:2], 2'b00});
        chk({nm, ":we"}, 32'(mem_we), 32'(wr));
        chk({nm, ":be"}, 32'(mem_be), wr ? 32'(be_ref(op, a[1:0])) : 32'hF);
        if (wr) chk({nm, ":wdata"}, mem_wdata, wd_ref(op, wd));
        if (granted < 0 && (n - 1) >= gdly) begin
          mem_gnt = 1'b1;
          granted = n;
        end
      end
      if (granted > 0 && !wr && n == granted + rdly) begin
        mem_rvalid = 1'b1;
        mem_rdata = word;
      end
      if (junk) begin
        req = 1'($urandom); memwr = 1'($urandom); memop = 3'($urandom);
        addr = $urandom; wdata = $urandom;
      end
      step();
      n++;
    end
    req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    chk({nm, ":done"}, 32'(got_done), 32'd1);
    chk({nm, ":lat"}, n, exp_lat);
    chk({nm, ":err"}, 32'(err), 32'(exp_err));
    chk({nm, ":mis"}, 32'(misalign), 32'(mis && !ill));
    chk({nm, ":bus_used"}, 32'(req_seen), 32'(!ill && !mis));
    if (exp_err) chk({nm, ":rdata0"}, rdata, 32'd0);
    else if (!wr && !mis) chk({nm, ":rdata"}, rdata, ld_ref(op, a[1:0], word));
    step();
    chk({nm, ":pulse"}, 32'(done), 32'd0);
    chk({nm, ":req_low"}, 32'(mem_req), 32'd0);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; memwr = 1'b0; memop = 3'd0; addr = '0; wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_flags", {err, misalign, mem_we}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_bus", mem_addr | mem_wdata | 32'(mem_be), 32'd0);
    rst = 1'b0;
    step();

    // directed
    do_op("sb",     1, 3'b000, 32'h1003, 32'h0000_00AB, 0, 0, 1, 0);
    do_op("lb",     0, 3'b000, 32'h2001, 32'h0, 32'h0000_8000, 0, 1, 0);
    do_op("lbu",    0, 3'b100, 32'h2001, 32'h0, 32'h0000_8000, 0, 1, 0);
    do_op("lhu",    0, 3'b101, 32'h2002, 32'h0, 32'hBEEF_0000, 0, 1, 0);
    do_op("lh",     0, 3'b001, 32'h2002, 32'h0, 32'hBEEF_0000, 0, 1, 0);
    do_op("sh",     1, 3'b001, 32'h2002, 32'h1234_5678, 32'h0, 1, 1, 0);
    do_op("sw",     1, 3'b010, 32'h2004, 32'hCAFE_F00D, 32'h0, 2, 1, 0);
    do_op("lw_mis", 0, 3'b010, 32'h2002, 32'h0, 32'h0, 0, 1, 0);
    do_op("sh_mis", 1, 3'b001, 32'h2001, 32'h0, 32'h0, 0, 1, 0);
    do_op("ill011", 0, 3'b011, 32'h2000, 32'h0, 32'h0, 0, 1, 0);
    do_op("ill_both", 0, 3'b111, 32'h2003, 32'h0, 32'h0, 0, 1, 0);
    do_op("ill_sbu",  1, 3'b100, 32'h2000, 32'h0, 32'h0, 0, 1, 0);
    do_op("lw_tmo", 0, 3'b010, 32'h4000, 32'h0, 32'h1111_2222, 9999, 1, 0);
    do_op("lw_ok",  0, 3'b010, 32'h4000, 32'h0, 32'h1111_2222, 0, 1, 0);
    do_op("sw_edge", 1, 3'b010, 32'h4008, 32'h5555_AAAA, 32'h0, TO - 1, 1, 0);
    do_op("lw_slow", 0, 3'b010, 32'h5004, 32'h0, 32'h8765_4321, 5, 3, 1);

    // randomized
    for (int i = 0; i < 60; i++) begin
      logic        w;
      logic [2:0]  o;
      w = 1'($urandom);
      o = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
      if (!w && $urandom_range(0, 2) == 0) o = o | 3'b100;
      do_op($sformatf("rnd%0d", i), w, o, $urandom, $urandom, $urandom,
            $urandom_range(0, 5), $urandom_range(1, 4), 1'($urandom));
    end

    // reset while in REQ: mem_req must drop without waiting for a clock
    req = 1'b1; memwr = 1'b0; memop = 3'b010; addr = 32'h3000;
    step();
    req = 1'b0;
    chk("rreq_req_hi", 32'(mem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rreq_req", 32'(mem_req), 32'd0);
    chk("rreq_busy", 32'(busy), 32'd0);
    #2 rst = 1'b0;
    step();

    // reset while in RWAIT, then a stray rvalid must not complete anything
    req = 1'b1; memwr = 1'b0; memop = 3'b010; addr = 32'h3000;
    step();
    req = 1'b0; mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("rrw_busy_hi", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rrw_busy", 32'(busy), 32'd0);
    chk("rrw_req", 32'(mem_req), 32'd0);
    #2 rst = 1'b0;
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 5; k++) begin
      step();
      mem_rvalid = 1'b0;
      chk("stray_done", 32'(done), 32'd0);
      chk("stray_busy", 32'(busy), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
